// File: rtl/vc_fifo_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vc_fifo_buffer_pkg
// Shared constants and width helpers for the multi-VC input buffer.
//   DATA_WIDTH_DEF : default flit width in bits
//   NUM_VC_DEF     : default number of virtual channels
//   clog2()        : ceiling log2, usable in parameter expressions
//   vc_width()     : VC index width, never below 1 bit
//   cnt_width()    : occupancy counter width (must hold the value DEPTH)
// ---------------------------------------------------------------------------
package vc_fifo_buffer_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_VC_DEF     = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? clog2(num_vc) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// ---------------------------------------------------------------------------
// vc_fifo_lane
// One circular FIFO of DEPTH entries. The caller only asserts push when the
// lane can accept (not full, or popping in the same cycle) and pop when it is
// not empty; the lane itself does no request qualification.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write strobe and flit
//   pop          : remove the head entry
//   head         : raw head entry (meaningless while empty)
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy == DEPTH / == 0
//   almost_full  : occupancy >= AF_LEVEL
// ---------------------------------------------------------------------------
module vc_fifo_lane
    import vc_fifo_buffer_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  DEPTH      = 4,
    parameter int  AF_LEVEL   = DEPTH - 1,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    // NOTE: storage has no reset; a location is only ever read after it has
    // been written, and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the PTR_W-bit pointers wrap DEPTH-1 -> 0
    // on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign count       = cnt;
    assign full        = (cnt == CNT_W'(DEPTH));
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= CNT_W'(AF_LEVEL));

endmodule

// File: rtl/vc_fifo_buffer.sv
// ---------------------------------------------------------------------------
// vc_fifo_buffer
// Multi-virtual-channel router input buffer: NUM_VC independent FIFOs of
// DEPTH flits behind one write port and one read port. First-word-fall-
// through: the head flit of rd_vc is always on data_out.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en, wr_vc, data_in : write request, target VC, flit
//   rd_en, rd_vc        : pop request and VC selecting data_out
//   data_out            : head flit of rd_vc, zero when that VC is empty
//   full, empty         : per-VC occupancy flags (state only)
//   almost_full         : per-VC count >= AF_LEVEL
//   count               : per-VC occupancy, VC v at [v*CNT_W +: CNT_W]
//   wr_err, rd_err      : one-cycle pulse after a rejected write / read
// ---------------------------------------------------------------------------
module vc_fifo_buffer
    import vc_fifo_buffer_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  DEPTH      = 4,
    parameter int  NUM_VC     = NUM_VC_DEF,
    parameter int  AF_LEVEL   = DEPTH - 1,
    localparam int VC_W       = vc_width(NUM_VC),
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    wr_err,
    output logic                    rd_err
);

    // Every encodable VC index gets a slot. Slots past NUM_VC look both full
    // and empty, so out-of-range requests are rejected by the ordinary
    // full/empty checks without a separate range compare.
    localparam int NUM_SLOT = 1 << VC_W;

    logic [NUM_VC-1:0]     lane_push;
    logic [NUM_VC-1:0]     lane_pop;
    logic [DATA_WIDTH-1:0] lane_head [NUM_VC];
    logic [CNT_W-1:0]      lane_count [NUM_VC];

    logic [NUM_SLOT-1:0]   slot_full;
    logic [NUM_SLOT-1:0]   slot_empty;
    logic [DATA_WIDTH-1:0] slot_head [NUM_SLOT];

    logic rd_accept;
    logic wr_accept;

    // A full VC still takes a write when the same cycle pops it.
    assign rd_accept = rd_en && !slot_empty[rd_vc];
    assign wr_accept = wr_en && (!slot_full[wr_vc] || (rd_accept && (rd_vc == wr_vc)));

    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
        assign lane_push[v] = wr_accept && (wr_vc == VC_W'(v));
        assign lane_pop[v]  = rd_accept && (rd_vc == VC_W'(v));

        vc_fifo_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (AF_LEVEL)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .push        (lane_push[v]),
            .din         (data_in),
            .pop         (lane_pop[v]),
            .head        (lane_head[v]),
            .count       (lane_count[v]),
            .full        (full[v]),
            .empty       (empty[v]),
            .almost_full (almost_full[v])
        );

        assign count[v*CNT_W +: CNT_W] = lane_count[v];
    end

    for (genvar s = 0; s < NUM_SLOT; s++) begin : g_slot
        if (s < NUM_VC) begin : g_real
            assign slot_full[s]  = full[s];
            assign slot_empty[s] = empty[s];
            assign slot_head[s]  = lane_head[s];
        end else begin : g_absent
            assign slot_full[s]  = 1'b1;
            assign slot_empty[s] = 1'b1;
            assign slot_head[s]  = '0;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves data_out
        // unassigned and a latch cannot be inferred.
        data_out = '0;
        if (!slot_empty[rd_vc]) begin
            data_out = slot_head[rd_vc];
        end
    end

    // Error pulses report the previous cycle's rejections; a reset cycle
    // discards its requests silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_accept;
            rd_err <= rd_en && !rd_accept;
        end
    end

endmodule
